// File: rtl/run_ctrl_if.sv
// run_ctrl_if: control/status bundle between the UART debug front end,
// the mu0 core and the run controller.
//   master : the side that drives mode/start/done/breakpoint inputs
//   slave  : the run controller itself
interface run_ctrl_if;
    logic [3:0]  clk_mode;
    logic        start;
    logic        done;
    logic [15:0] pc;
    logic [15:0] bp_addr;
    logic        bp_valid;
    logic        enable;
    logic        cpu_tick;
    logic [31:0] cycle_count;
    logic [1:0]  halt_cause;

    modport master (
        output clk_mode, start, done, pc, bp_addr, bp_valid,
        input  enable, cpu_tick, cycle_count, halt_cause
    );

    modport slave (
        input  clk_mode, start, done, pc, bp_addr, bp_valid,
        output enable, cpu_tick, cycle_count, halt_cause
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: run controller for the mu0 core.
// Converts the UART start toggle, the core's done flag and the selected
// clock mode into a single-cycle advance strobe (cpu_tick) and a run
// enable, all inside the clk domain (no derived clocks). Also keeps a
// saturating tick counter and the cause of the last halt.
// Optional feature: define RUN_CTRL_BREAKPOINT_EN to enable the PC
// breakpoint (pc/bp_addr/bp_valid are ignored otherwise).
module run_ctrl #(
    parameter int unsigned SLOW_DIV = 6318000,  // clk cycles per slow tick, >= 2
    parameter int          CNT_W    = 32        // slow divider width
) (
    input  logic     clk,
    input  logic     reset_n,
    run_ctrl_if.slave ctl
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MODE_FAST    = 4'd1;
    localparam logic [3:0] MODE_SLOW    = 4'd2;
    localparam logic [3:0] MODE_MAN_OFF = 4'd3;
    localparam logic [3:0] MODE_MAN_ON  = 4'd4;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_DONE = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SLOW_DIV - 1);

    state_t      state_reg, state_next;
    logic        start_q_reg;
    logic [3:0]  mode_q_reg;
    logic [CNT_W-1:0] div_reg, div_next;
    logic        phase_reg, phase_next;
    logic        tick_reg, tick_next;
    logic [31:0] count_reg, count_next;
    logic [1:0]  cause_reg, cause_next;

    logic start_req;
    logic mode_change;
    logic fast_fire;
    logic slow_fire;
    logic man_fire;
    logic fire;
    logic bp_hit;

    // Any level change of the start toggle is a start request; any change of
    // the mode restarts the divider and phase.
    assign start_req   = (ctl.start != start_q_reg);
    assign mode_change = (ctl.clk_mode != mode_q_reg);

    // Divider and phase advance: only the selected timebase runs, the other
    // one (and everything in OFF/illegal modes) is held at zero.
    always_comb begin
        div_next   = '0;
        phase_next = 1'b0;
        if (!mode_change) begin
            case (ctl.clk_mode)
                MODE_FAST: phase_next = ~phase_reg;
                MODE_SLOW: div_next   = (div_reg >= DIV_LAST) ? '0 : div_reg + 1'b1;
                default:   ;
            endcase
        end
    end

    // Tick sources. Manual mode fires on a 3->4 transition between
    // consecutive samples of clk_mode.
    assign fast_fire = (ctl.clk_mode == MODE_FAST) && phase_reg && !mode_change;
    assign slow_fire = (ctl.clk_mode == MODE_SLOW) && (div_reg == DIV_LAST) && !mode_change;
    assign man_fire  = (mode_q_reg == MODE_MAN_OFF) && (ctl.clk_mode == MODE_MAN_ON);
    assign fire      = fast_fire || slow_fire || man_fire;

`ifdef RUN_CTRL_BREAKPOINT_EN
    // Suppress stays set from a start until the first issued tick, so a run
    // can be restarted while pc still sits on the breakpoint address.
    logic suppress_reg, suppress_next;

    assign bp_hit = (state_reg == RUN) && ctl.bp_valid &&
                    (ctl.pc == ctl.bp_addr) && !suppress_reg;

    // Suppress flag: set by a start, cleared by the first tick after it.
    always_comb begin
        suppress_next = suppress_reg;
        if (start_req) begin
            suppress_next = 1'b1;
        end else if (tick_next) begin
            suppress_next = 1'b0;
        end
    end

    // Suppress flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            suppress_reg <= 1'b0;
        end else begin
            suppress_reg <= suppress_next;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    // Run FSM next state and halt cause. A start beats done and breakpoint;
    // done beats breakpoint when both occur together.
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            IDLE: begin
                if (start_req) begin
                    state_next = RUN;
                    cause_next = CAUSE_NONE;
                end
            end
            RUN: begin
                if (start_req) begin
                    cause_next = CAUSE_NONE;
                end else if (ctl.done) begin
                    state_next = IDLE;
                    cause_next = CAUSE_DONE;
                end else if (bp_hit) begin
                    state_next = IDLE;
                    cause_next = CAUSE_BP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Tick and counter: a tick needs RUN both now and next cycle, so the first
    // tick after a start is at least two cycles after it and nothing issues
    // once a stop is taken. A start clears the counter and swallows any
    // coincident tick.
    always_comb begin
        tick_next  = (state_reg == RUN) && (state_next == RUN) && fire && !tick_reg;
        count_next = count_reg;
        if (start_req) begin
            count_next = '0;
        end else if (tick_next && (count_reg != 32'hFFFF_FFFF)) begin
            count_next = count_reg + 32'd1;
        end
    end

    // State register for the FSM, input history, timebase and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            start_q_reg <= 1'b0;
            mode_q_reg  <= 4'd0;
            div_reg     <= '0;
            phase_reg   <= 1'b0;
            tick_reg    <= 1'b0;
            count_reg   <= '0;
            cause_reg   <= CAUSE_NONE;
        end else begin
            state_reg   <= state_next;
            start_q_reg <= ctl.start;
            mode_q_reg  <= ctl.clk_mode;
            div_reg     <= div_next;
            phase_reg   <= phase_next;
            tick_reg    <= tick_next;
            count_reg   <= count_next;
            cause_reg   <= cause_next;
        end
    end

    assign ctl.enable      = (state_reg == RUN);
    assign ctl.cpu_tick    = tick_reg;
    assign ctl.cycle_count = count_reg;
    assign ctl.halt_cause  = cause_reg;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: table-driven check of run_ctrl with SLOW_DIV=4.
// Expected outputs for each vector are queued when the vector is driven and
// compared after the following clock edge.
module tb_run_ctrl;

    typedef struct {
        logic        start;
        logic        done;
        logic [3:0]  mode;
        logic [15:0] pc;
        logic        bpv;
        logic        en;
        logic        tick;
        logic [31:0] cnt;
        logic [1:0]  cause;
    } vec_t;

`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    run_ctrl_if bus();

    int checks = 0;
    int errors = 0;

    vec_t vecs[80];
    int   nvec = 0;
    vec_t exp_q[$];

    run_ctrl #(.SLOW_DIV(4), .CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctl     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic d, input logic [3:0] m, input logic [15:0] p,
                       input logic bv, input logic en, input logic tk, input logic [31:0] cn,
                       input logic [1:0] ca);
        vecs[nvec] = '{start: s, done: d, mode: m, pc: p, bpv: bv,
                       en: en, tick: tk, cnt: cn, cause: ca};
        nvec++;
    endtask

    initial begin
        vec_t e;
        vec_t v;
        bit reached;

        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.done     = 1'b0;
        bus.clk_mode = 4'd0;
        bus.pc       = 16'd0;
        bus.bp_addr  = 16'h0005;
        bus.bp_valid = 1'b0;

        // FAST mode, start, ticks every second cycle
        add(0,0,1,0,0, 0,0,0,0);  // 0
        add(0,0,1,0,0, 0,0,0,0);  // 1
        add(1,0,1,0,0, 1,0,0,0);  // 2 start
        add(1,0,1,0,0, 1,0,0,0);  // 3
        add(1,0,1,0,0, 1,1,1,0);  // 4 first tick
        add(1,0,1,0,0, 1,0,1,0);
        add(1,0,1,0,0, 1,1,2,0);
        add(1,0,1,0,0, 1,0,2,0);
        add(1,0,1,0,0, 1,1,3,0);
        add(1,0,1,0,0, 1,0,3,0);
        add(1,0,1,0,0, 1,1,4,0);
        add(1,0,1,0,0, 1,0,4,0);
        add(1,0,1,0,0, 1,1,5,0);  // 12: 10 cycles of RUN -> 5
        // done stops, done in IDLE ignored
        add(1,1,1,0,0, 0,0,5,1);  // 13
        add(1,0,1,0,0, 0,0,5,1);
        add(1,1,1,0,0, 0,0,5,1);  // 15
        // restart, then start+done together, then done alone on a fire cycle
        add(0,0,1,0,0, 1,0,0,0);  // 16
        add(0,0,1,0,0, 1,0,0,0);
        add(0,0,1,0,0, 1,1,1,0);  // 18
        add(1,1,1,0,0, 1,0,0,0);  // 19 start wins
        add(1,1,1,0,0, 0,0,0,1);  // 20 done alone
        // SLOW mode, one tick per 4 cycles, OFF mid-count
        add(0,0,2,0,0, 1,0,0,0);  // 21
        add(0,0,2,0,0, 1,0,0,0);
        add(0,0,2,0,0, 1,0,0,0);
        add(0,0,2,0,0, 1,0,0,0);
        add(0,0,2,0,0, 1,1,1,0);  // 25
        add(0,0,2,0,0, 1,0,1,0);
        add(0,0,2,0,0, 1,0,1,0);
        add(0,0,2,0,0, 1,0,1,0);
        add(0,0,2,0,0, 1,1,2,0);  // 29
        add(0,0,2,0,0, 1,0,2,0);
        add(0,0,2,0,0, 1,0,2,0);
        add(0,0,0,0,0, 1,0,2,0);  // 32 OFF
        add(0,0,0,0,0, 1,0,2,0);
        add(0,0,0,0,0, 1,0,2,0);
        add(0,0,0,0,0, 1,0,2,0);
        add(0,0,0,0,0, 1,0,2,0);
        add(0,0,2,0,0, 1,0,2,0);  // 37 SLOW again, divider restarts
        add(0,0,2,0,0, 1,0,2,0);
        add(0,0,2,0,0, 1,0,2,0);
        add(0,0,2,0,0, 1,0,2,0);
        add(0,0,2,0,0, 1,1,3,0);  // 41
        // MANUAL 3,4,4,3,4 -> two ticks
        add(0,0,3,0,0, 1,0,3,0);
        add(0,0,4,0,0, 1,1,4,0);
        add(0,0,4,0,0, 1,0,4,0);
        add(0,0,3,0,0, 1,0,4,0);
        add(0,0,4,0,0, 1,1,5,0);
        add(0,0,4,0,0, 1,0,5,0);
        // MANUAL while stopped -> no ticks
        add(0,1,4,0,0, 0,0,5,1);  // 48
        add(0,0,3,0,0, 0,0,5,1);
        add(0,0,4,0,0, 0,0,5,1);
        add(0,0,4,0,0, 0,0,5,1);
        // breakpoint at 5: restart on pc=5 gives one tick first
        add(1,0,1,5,1, 1,0,0,0);  // 52
        add(1,0,1,5,1, 1,0,0,0);
        add(1,0,1,5,1, 1,1,1,0);  // 54
        if (BP_EN) begin
            add(1,0,1,5,1, 0,0,1,3);
            add(1,0,1,5,1, 0,0,1,3);
        end else begin
            add(1,0,1,5,1, 1,0,1,0);
            add(1,0,1,5,1, 1,1,2,0);
        end
        // breakpoint reached by pc moving onto it
        add(0,0,1,0,1, 1,0,0,0);  // 57
        add(0,0,1,0,1, 1,1,1,0);
        add(0,0,1,3,1, 1,0,1,0);
        if (BP_EN) begin
            add(0,0,1,5,1, 0,0,1,3);
            add(0,0,1,5,1, 0,0,1,3);
        end else begin
            add(0,0,1,5,1, 1,1,2,0);
            add(0,0,1,5,1, 1,0,2,0);
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_enable", 32'(bus.enable), 32'd0);
        check("reset_tick",   32'(bus.cpu_tick), 32'd0);
        check("reset_count",  bus.cycle_count, 32'd0);
        check("reset_cause",  32'(bus.halt_cause), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            v = vecs[i];
            bus.start    = v.start;
            bus.done     = v.done;
            bus.clk_mode = v.mode;
            bus.pc       = v.pc;
            bus.bp_valid = v.bpv;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("vec %0d: start=%0b done=%0b mode=%0d pc=%0d -> en=%0b tick=%0b cnt=%0d cause=%0d",
                     i, v.start, v.done, v.mode, v.pc,
                     bus.enable, bus.cpu_tick, bus.cycle_count, bus.halt_cause);
            check($sformatf("vec%0d_enable", i), 32'(bus.enable), 32'(e.en));
            check($sformatf("vec%0d_tick", i),   32'(bus.cpu_tick), 32'(e.tick));
            check($sformatf("vec%0d_count", i),  bus.cycle_count, e.cnt);
            check($sformatf("vec%0d_cause", i),  32'(bus.halt_cause), 32'(e.cause));
        end

        // run to cycle_count 0x10, then pulse reset between clock edges
        bus.start    = 1'b1;
        bus.done     = 1'b0;
        bus.clk_mode = 4'd1;
        bus.pc       = 16'd0;
        bus.bp_valid = 1'b0;
        reached      = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(posedge clk);
            #1;
            if (bus.cycle_count == 32'h10) reached = 1'b1;
        end
        $display("run to 0x10: reached=%0b cnt=0x%0h", reached, bus.cycle_count);
        check("reach_count_0x10", 32'(reached), 32'd1);
        check("count_before_reset", bus.cycle_count, 32'h10);
        check("enable_before_reset", 32'(bus.enable), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset: en=%0b tick=%0b cnt=0x%0h cause=%0d",
                 bus.enable, bus.cpu_tick, bus.cycle_count, bus.halt_cause);
        check("async_reset_enable", 32'(bus.enable), 32'd0);
        check("async_reset_tick",   32'(bus.cpu_tick), 32'd0);
        check("async_reset_count",  bus.cycle_count, 32'd0);
        check("async_reset_cause",  32'(bus.halt_cause), 32'd0);

        // release reset with start held high: start seen on the first edge
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        $display("release with start=1: en=%0b tick=%0b cnt=%0d cause=%0d",
                 bus.enable, bus.cpu_tick, bus.cycle_count, bus.halt_cause);
        check("release_start_enable", 32'(bus.enable), 32'd1);
        check("release_start_tick",   32'(bus.cpu_tick), 32'd0);
        check("release_start_count",  bus.cycle_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
